// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: a 32-bit value becomes 8 BCD digits (sequential double-dabble) or 8 raw
//   hex nibbles, is double-buffered, and is scanned onto one shared 7-segment bus across 8 anodes.
// Latency: hex load updates the display 1 cycle after accept; decimal updates it 33 cycles after
//   accept. seg/an are registered and trail the digit index (and display register) by 1 cycle.
// Backpressure: wr_ready is high only in IDLE; wr_valid is ignored otherwise, so the requester holds it.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks leading zero digits of decimal values.
module seven_seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          SEG_ACT_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  input  logic        wr_hex,
  output logic        busy,
  output logic        ovf,
  output logic [6:0]  seg,
  output logic [7:0]  an
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      bin_q, bin_d;     // binary shift source; also holds the raw hex word
  logic             hex_q, hex_d;
  logic [39:0]      bcd_q, bcd_d;
  logic [4:0]       iter_q, iter_d;
  logic [31:0]      disp_q, disp_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [7:0]       an_q, an_d;
  logic [38:0]      bcd_adj;
  logic             accept;

  // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      default: p = 7'h71;
    endcase
    return p;
  endfunction

  assign wr_ready = (state_q == S_IDLE) && !rst;
  assign accept   = wr_valid && wr_ready;
  assign busy     = (state_q == S_CONV);
  assign ovf      = ovf_q;
  assign seg      = seg_q;
  assign an       = an_q;

  // Add-3 correction on every BCD digit >= 5. The top digit never exceeds 4 for a 32-bit
  // input, so its MSB is never needed after the shift.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 9; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? (bcd_q[4*i +: 4] + 4'd3) : bcd_q[4*i +: 4];
    end
    bcd_adj[38:36] = bcd_q[38:36];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus conversion / display-buffer datapath.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    hex_d   = hex_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          bin_d   = wr_data;
          hex_d   = wr_hex;
          bcd_d   = '0;
          iter_d  = '0;
          state_d = wr_hex ? S_LOAD : S_CONV;
        end
      end
      S_CONV: begin
        bcd_d  = {bcd_adj, bin_q[31]};
        bin_d  = {bin_q[30:0], 1'b0};
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'd31) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (hex_q) begin
          disp_d = bin_q;
          ovf_d  = 1'b0;
        end else begin
          disp_d = bcd_q[31:0];
          ovf_d  = |bcd_q[39:32];
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers; reset clears the display so an aborted conversion leaves nothing stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      hex_q  <= 1'b0;
      bcd_q  <= '0;
      iter_q <= '0;
      disp_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      hex_q  <= hex_d;
      bcd_q  <= bcd_d;
      iter_q <= iter_d;
      disp_q <= disp_d;
      ovf_q  <= ovf_d;
    end
  end

  // Refresh counter; each wrap advances to the next digit, 7 wraps back to 0.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic disp_hex_q;

  // Remember which mode produced the displayed value; only decimal values get blanked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_hex_q <= 1'b0;
    end else if (state_q == S_LOAD) begin
      disp_hex_q <= hex_q;
    end
  end
`endif

  // Pattern and anode for the current digit, registered together so they never disagree.
  always_comb begin
    logic [6:0] pat;
    logic [7:0] onehot;
    pat    = ovf_q ? 7'h40 : seg_decode(disp_q[{idx_q, 2'b00} +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
    if (!ovf_q && !disp_hex_q && (idx_q != 3'd0) && ((disp_q >> {idx_q, 2'b00}) == 32'd0)) begin
      pat = 7'h00;
    end
`endif
    onehot = 8'b1 << idx_q;
    seg_d  = SEG_ACT_LOW ? ~pat : pat;
    an_d   = SEG_ACT_LOW ? ~onehot : onehot;
  end

  // Scan registers; reset leaves all anodes off and the segment bus blank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_ACT_LOW ? 7'h7F : 7'h00;
      an_q  <= SEG_ACT_LOW ? 8'hFF : 8'h00;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: drives seven_seg_scan_ctrl with REFRESH_DIV=4, active-low outputs.
// Latency: n/a (testbench).
// Backpressure: requester holds wr_valid/wr_data until the write is accepted.
module tb_seven_seg_scan_ctrl;

  localparam int RD = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        wr_hex;
  logic        busy;
  logic        ovf;
  logic [6:0]  seg;
  logic [7:0]  an;

  seven_seg_scan_ctrl #(.REFRESH_DIV(RD), .SEG_ACT_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_hex(wr_hex), .busy(busy), .ovf(ovf), .seg(seg), .an(an)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: what is displayed, what is in flight, and how many edges since reset.
  int          m_n;
  logic [31:0] m_val;
  logic        m_hex;
  logic        m_ready;
  logic        m_pend;
  logic [31:0] m_pend_val;
  logic        m_pend_hex;
  int          m_acc_edge;
  logic [6:0]  m_seg;
  logic [7:0]  m_an;
  logic [6:0]  seen [8];

  typedef struct packed {
    logic [31:0]     data;
    logic            hex;
    logic            ovf;
    logic [7:0][6:0] seg;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Active-low pattern for a digit value 0..15.
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // Expected pattern of digit i, computed with plain decimal / hex arithmetic.
  function automatic logic [6:0] exp_pat(input logic [31:0] v, input logic hx, input int i);
    longint unsigned p;
    int d;
    if (!hx && v > 32'd99_999_999) return 7'h3F;
    if (hx) begin
      d = int'((v >> (4 * i)) & 32'hF);
    end else begin
      p = 1;
      for (int j = 0; j < i; j++) p = p * 10;
      d = int'((longint'(v) / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && longint'(v) < p) return 7'h7F;
`endif
    end
    return seg_of(d);
  endfunction

  task automatic model_reset();
    m_n = 0; m_val = '0; m_hex = 1'b0; m_ready = 1'b1; m_pend = 1'b0;
    m_pend_val = '0; m_pend_hex = 1'b0; m_acc_edge = -100;
    m_seg = 7'h7F; m_an = 8'hFF;
  endtask

  // One clock edge: advance the model, then compare every output on the falling edge.
  task automatic tick();
    int   idx;
    logic acc;
    logic exp_busy;
    logic exp_ovf;
    @(posedge clk);
    idx   = (m_n / RD) % 8;
    m_seg = exp_pat(m_val, m_hex, idx);
    m_an  = ~(8'b1 << idx);
    acc   = wr_valid && m_ready;
    m_n++;
    if (m_pend && m_n == m_acc_edge + (m_pend_hex ? 1 : 33)) begin
      m_val = m_pend_val; m_hex = m_pend_hex; m_pend = 1'b0; m_ready = 1'b1;
    end
    if (acc) begin
      m_pend = 1'b1; m_pend_val = wr_data; m_pend_hex = wr_hex; m_acc_edge = m_n; m_ready = 1'b0;
    end
    exp_busy = m_pend && !m_pend_hex && ((m_n - m_acc_edge) <= 31);
    exp_ovf  = !m_hex && (m_val > 32'd99_999_999);
    @(negedge clk);
    chk("seg", {25'd0, seg}, {25'd0, m_seg});
    chk("an", {24'd0, an}, {24'd0, m_an});
    chk("busy", {31'd0, busy}, {31'd0, exp_busy});
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, m_ready});
    chk("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
  endtask

  // Asynchronous reset asserted between edges; outputs must go dark immediately.
  task automatic do_reset();
    wr_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_an", {24'd0, an}, 32'hFF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rel_ready", {31'd0, wr_ready}, 32'd1);
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!wr_ready && w < 100) begin tick(); w++; end
    chk("ready_wait", {31'd0, wr_ready}, 32'd1);
  endtask

  // Record the pattern seen on each anode over n samples.
  task automatic scan(input int n);
    int oh_bad = 0;
    for (int i = 0; i < 8; i++) seen[i] = 7'h55;
    for (int c = 0; c < n; c++) begin
      logic hit = 1'b0;
      for (int j = 0; j < 8; j++) begin
        if (an == ~(8'b1 << j)) begin seen[j] = seg; hit = 1'b1; end
      end
      if (!hit) oh_bad++;
      tick();
    end
    chk("onehot_bad", oh_bad, 0);
  endtask

  task automatic apply_vec(input vec_t v, input int vi);
    int cyc;
    int busy_cnt;
    wait_ready();
    wr_valid = 1'b1; wr_data = v.data; wr_hex = v.hex;
    tick();
    wr_valid = 1'b0;
    chk("ready_drop", {31'd0, wr_ready}, 32'd0);
    busy_cnt = busy ? 1 : 0;
    cyc = 0;
    while (!wr_ready && cyc < 100) begin
      tick(); cyc++;
      if (busy) busy_cnt++;
    end
    chk($sformatf("latency[%0d]", vi), cyc, v.hex ? 1 : 33);
    chk($sformatf("busy_cycles[%0d]", vi), busy_cnt, v.hex ? 0 : 32);
    chk($sformatf("vec_ovf[%0d]", vi), {31'd0, ovf}, {31'd0, v.ovf});
    tick();
    scan(40);
    for (int i = 0; i < 8; i++)
      chk($sformatf("vec[%0d].digit%0d", vi, i), {25'd0, seen[i]}, {25'd0, v.seg[i]});
  endtask

  initial begin
    int t;
    int t_ready;
    vecs[0] = '{32'd91,         1'b0, 1'b0, {{6{LZ}}, 7'h10, 7'h79}};
    vecs[1] = '{32'hDEADBEEF,   1'b1, 1'b0, {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E}};
    vecs[2] = '{32'd100_000_000, 1'b0, 1'b1, {8{7'h3F}}};
    vecs[3] = '{32'd66,         1'b0, 1'b0, {{6{LZ}}, 7'h02, 7'h02}};
    vecs[4] = '{32'd99_999_999, 1'b0, 1'b0, {8{7'h10}}};
    vecs[5] = '{32'd0,          1'b0, 1'b0, {{7{LZ}}, 7'h40}};
    vecs[6] = '{32'h0,          1'b1, 1'b0, {8{7'h40}}};
    vecs[7] = '{32'hFFFFFFFF,   1'b0, 1'b1, {8{7'h3F}}};
    vecs[8] = '{32'h01234567,   1'b1, 1'b0, {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78}};
    vecs[9] = '{32'd12_345_678, 1'b0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}};

    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_hex = 1'b0;
    model_reset();
    #1;
    chk("init_an", {24'd0, an}, 32'hFF);
    chk("init_seg", {25'd0, seg}, 32'h7F);
    chk("init_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("init_ready", {31'd0, wr_ready}, 32'd1);
    tick();
    chk("first_digit0", {25'd0, seg}, 32'h40);

    // Reset in the middle of a scan.
    for (int i = 0; i < 13; i++) tick();
    do_reset();
    tick();

    // Table-driven writes.
    for (int i = 0; i < 10; i++) apply_vec(vecs[i], i);

    // Back-pressure: 78 held during the conversion of 67, accepted on the first IDLE cycle.
    wait_ready();
    wr_valid = 1'b1; wr_data = 32'd67; wr_hex = 1'b0;
    tick();
    wr_data = 32'd78;
    t = 0; t_ready = -1;
    while (t_ready < 0 && t < 100) begin
      tick(); t++;
      if (wr_ready) t_ready = t;
    end
    chk("bp_ready_after", t_ready, 33);
    tick();
    wr_valid = 1'b0;
    chk("bp_accept_first_idle", {31'd0, wr_ready}, 32'd0);
    scan(32);
    chk("bp_first_d0", {25'd0, seen[0]}, 32'h78);
    chk("bp_first_d1", {25'd0, seen[1]}, 32'h02);
    wait_ready();
    tick();
    scan(40);
    chk("bp_second_d0", {25'd0, seen[0]}, 32'h00);
    chk("bp_second_d1", {25'd0, seen[1]}, 32'h78);

    // Reset at conversion iteration 10, on top of an overflowed display.
    apply_vec(vecs[2], 2);
    wr_valid = 1'b1; wr_data = 32'd55; wr_hex = 1'b0;
    tick();
    wr_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    do_reset();
    for (int i = 0; i < 40; i++) tick();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ovf", {31'd0, ovf}, 32'd0);
    scan(40);
    chk("abort_d0", {25'd0, seen[0]}, 32'h40);
    chk("abort_d7", {25'd0, seen[7]}, {25'd0, LZ});
    apply_vec(vecs[3], 3);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (!wr_valid && $urandom_range(0, 3) == 0) begin
        wr_valid = 1'b1;
        wr_hex   = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0: wr_data = $urandom;
          1: wr_data = $urandom_range(0, 999);
          2: wr_data = $urandom_range(0, 99_999_999);
          default: wr_data = $urandom_range(99_999_990, 100_000_010);
        endcase
      end
      tick();
      if (wr_valid && m_pend && m_acc_edge == m_n) wr_valid = 1'b0;
    end
    wr_valid = 1'b0;
    t = 0;
    while (m_pend && t < 100) begin tick(); t++; end
    chk("drain", {31'd0, m_pend}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
